// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (signed/unsigned) with fixed 33-cycle latency.
// One shift-subtract step per CALC cycle; results are registered on the last step.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sign_en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              annul,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_nx;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W:0]   rem_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] a_raw_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic              zero_q;

    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;
    logic              fits;
    logic [DATA_W:0]   rem_nx;
    logic [DATA_W-1:0] quo_nx;
    logic              last_step;
    logic              accept;
    logic              finish;

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                 input logic en);
        return (en && v[DATA_W-1]) ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic signed [DATA_W-1:0] v,
                                                  input logic neg);
        return neg ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign stall     = (start && (state_q == IDLE) && !annul) || (state_q == CALC);
    assign last_step = (cnt_q == CNT_W'(DATA_W - 1));
    assign accept    = (state_q == IDLE) && start && !annul;
    assign finish    = (state_q == CALC) && !annul && last_step;

    // Restoring step: bring in next dividend bit, subtract divisor if it fits
    always_comb begin
        shifted = {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        fits    = ~diff[DATA_W+1];
        rem_nx  = fits ? diff[DATA_W:0] : shifted;
        quo_nx  = {dvd_q[DATA_W-2:0], fits};
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (start && !annul) state_nx = CALC;
            CALC: begin
                if (annul)          state_nx = IDLE;
                else if (last_step) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            a_raw_q   <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            zero_q    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q   <= '0;
                dvd_q   <= abs_val(a, sign_en);
                dvs_q   <= abs_val(b, sign_en);
                rem_q   <= '0;
                a_raw_q <= a;
                q_neg_q <= (a[DATA_W-1] ^ b[DATA_W-1]) & sign_en;
                r_neg_q <= a[DATA_W-1] & sign_en;
                zero_q  <= (b == '0);
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 1'b1;
                dvd_q <= quo_nx;
                rem_q <= rem_nx;
            end
            // A zero divisor bypasses the datapath result with fixed values
            if (finish) begin
                quotient  <= zero_q ? '1 : cond_neg(quo_nx, q_neg_q);
                remainder <= zero_q ? a_raw_q : cond_neg(rem_nx[DATA_W-1:0], r_neg_q);
                div_zero  <= zero_q;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at start, checked on done.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign_en;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign_en   (sign_en),
        .a         (a),
        .b         (b),
        .annul     (annul),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    logic        last_z = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic s, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        xs = x;
        ys = y;
        z  = 1'b0;
        if (y == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = x;
            z = 1'b1;
        end else if (!s) begin
            q = x / y;
            r = x % y;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else begin
            q = xs / ys;
            r = xs % ys;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_zero", 32'(div_zero), 32'(e.z));
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic z);
        sb.push_back(exp_t'{q, r, z, cyc + 33});
        last_q = q;
        last_r = r;
        last_z = z;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    // Called at posedge+1 with the divider idle
    task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
        start = 1'b1; sign_en = s; a = x; b = y;
        push_exp(eq, er, ez);
        #1;
        check("stall_start", 32'(stall), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_calc", 32'(busy), 32'd1);
        drain();
    endtask

    initial begin
        logic [31:0] mq, mr, x, y;
        logic        mz, s;
        int          d0;

        rst = 1'b1; start = 1'b0; sign_en = 1'b0; a = '0; b = '0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        @(posedge clk); #1;

        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        do_op(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        do_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            s = 1'((i >> 1) & 1);
            x = $urandom;
            y = (i % 2 == 1) ? 32'($urandom) : 32'($urandom_range(1, 100));
            model(s, x, y, mq, mr, mz);
            do_op(s, x, y, mq, mr, mz);
        end

        // annul in IDLE blocks start and drops stall
        start = 1'b1; annul = 1'b1; a = 32'd50; b = 32'd5; sign_en = 1'b0;
        #1;
        check("stall_annul_idle", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        check("annul_blocks_start", 32'(busy), 32'd0);

        // annul in CALC cycle 10: back to IDLE, outputs held, restart completes
        start = 1'b1; a = 32'd1000; b = 32'd3; sign_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul_idle", 32'(busy), 32'd0);
        check("annul_q_hold", quotient, last_q);
        check("annul_r_hold", remainder, last_r);
        check("annul_z_hold", 32'(div_zero), 32'(last_z));
        @(posedge clk); #1;
        do_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

        // annul in DONE is ignored
        model(1'b1, 32'hFFFFFF00, 32'd16, mq, mr, mz);
        start = 1'b1; a = 32'hFFFFFF00; b = 32'd16; sign_en = 1'b1;
        push_exp(mq, mr, mz);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        drain();

        // start pulses during CALC are ignored
        d0 = done_cnt;
        start = 1'b1; a = 32'd99; b = 32'd10; sign_en = 1'b0;
        push_exp(32'd9, 32'd9, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; a = 32'd5; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        start = 1'b1; a = 32'd7; b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (40) @(posedge clk);
        #1;
        check("one_done", done_cnt - d0, 1);

        // reset mid-CALC aborts with outputs cleared and no done
        start = 1'b1; a = 32'd12345; b = 32'd11; sign_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; annul = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_div_zero", 32'(div_zero), 32'd0);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 0);

        do_op(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request a division; it is sampled only in state IDLE.
REQ-004 The block SHALL have the port sign_en, input, 1 bit: 1 selects signed (div), 0 selects unsigned (divu); it is sampled with start.
REQ-005 The block SHALL have the port a, input, 32 bits: dividend, sampled with start.
REQ-006 The block SHALL have the port b, input, 32 bits: divisor, sampled with start.
REQ-007 The block SHALL have the port annul, input, 1 bit: cancels an in-flight division (pipeline flush or exception).
REQ-008 The block SHALL have the port busy, output, 1 bit: high while in state CALC.
REQ-009 The block SHALL have the port stall, output, 1 bit: combinational, equal to (start & IDLE & ~annul) | CALC; it freezes the upstream pipeline.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle pulse; results are valid in the same cycle.
REQ-011 The block SHALL have the port quotient, output, 32 bits: registered result, written to LO.
REQ-012 The block SHALL have the port remainder, output, 32 bits: registered result, written to HI.
REQ-013 The block SHALL have the port div_zero, output, 1 bit: registered; high with done when b was 0.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-015 IDLE SHALL move to CALC when start=1 and annul=0; at that edge it SHALL latch |a|, |b| (two's-complement absolute value when sign_en=1, raw when 0), the quotient sign (a[31]^b[31])&sign_en, the remainder sign a[31]&sign_en, and the b==0 flag, and clear the iteration counter.
REQ-016 CALC SHALL perform exactly one restoring shift-subtract step per cycle using a 33-bit partial remainder, for 32 cycles; on the edge of the 32nd CALC cycle it SHALL enter DONE.
REQ-017 On entry to DONE the block SHALL register the final outputs: quotient negated if its sign bit is set, remainder negated if its sign bit is set.
REQ-018 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: with start accepted in cycle 0, busy is high in cycles 1..32 and done is high in cycle 33, independent of operand values.
REQ-020 quotient, remainder and div_zero SHALL hold their values from DONE until the next DONE or a reset.
REQ-021 start SHALL be ignored in CALC and DONE; no queuing occurs.
REQ-022 When b=0, the operation SHALL take the same latency and produce quotient=32'hFFFFFFFF, remainder=a (unmodified) and div_zero=1; otherwise div_zero=0.
REQ-023 The signed operation 32'h80000000 / 32'hFFFFFFFF SHALL produce quotient=32'h80000000 and remainder=0, with no trap.
REQ-024 When annul=1 in CALC, the next state SHALL be IDLE, no done pulse SHALL occur, and the registered outputs SHALL keep their prior values.
REQ-025 annul=1 in IDLE SHALL block acceptance of start; annul in DONE SHALL have no effect, and done still pulses.
REQ-026 When annul=1 and start=1 arrive in the same IDLE cycle, annul SHALL win.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter and all working registers.
REQ-028 Reset SHALL drive busy=0, done=0, quotient=0, remainder=0 and div_zero=0.
REQ-029 rst SHALL take priority over start and annul.
REQ-030 rst asserted mid-CALC SHALL abort the operation with no done pulse.

Verification
REQ-031 The bench SHALL cover unsigned division: start, sign_en=0, a=100, b=7 -> done in cycle 33 with quotient=14, remainder=2, div_zero=0.
REQ-032 The bench SHALL cover signed division: a=-7 (32'hFFFFFFF9), b=2 -> quotient=32'hFFFFFFFD (-3), remainder=32'hFFFFFFFF (-1).
REQ-033 The bench SHALL cover divide by zero: a=32'h12345678, b=0 -> cycle 33 gives quotient=32'hFFFFFFFF, remainder=32'h12345678, div_zero=1.
REQ-034 The bench SHALL cover the signed overflow case: a=32'h80000000, b=32'hFFFFFFFF, sign_en=1 -> quotient=32'h80000000, remainder=0.
REQ-035 The bench SHALL cover annul: annul in cycle 10 of CALC -> IDLE in cycle 11, no done, outputs unchanged; a new start in cycle 12 completes normally in cycle 45.
REQ-036 The bench SHALL cover reset and ignored start: rst mid-CALC -> all outputs 0 next cycle; start pulses during CALC are ignored and exactly one done is observed.
